debug_run_ctrl: RTL and testbench

- Execution controller between the UART debug front-end and the pipelined MIPS core (TOP_TOP).
- Decodes one-byte debug commands and gates the pipeline clock-enable for continuous run or single-step.
- Detects HALT retirement, counts executed cycles, and hands off to the register/memory dump logic through a request/done handshake.

---
 rtl/debug_run_ctrl.sv | 125 ++++++++++++
 tb/tb_debug_run_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_run_ctrl.sv
// Execution controller for the debug front-end. It decodes one-byte
// commands, gates the pipeline enable for continuous run or single step,
// counts executed cycles and hands off to the dump logic with a
// request/done handshake.
module debug_run_ctrl #(
  parameter int          CYC_W    = 32,
  parameter logic [7:0]  CMD_RUN  = 8'h43,
  parameter logic [7:0]  CMD_STEP = 8'h53,
  parameter logic [7:0]  CMD_DUMP = 8'h44,
  parameter logic [7:0]  CMD_RST  = 8'h52
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       i_cmd,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_halt,
  output logic             o_pipe_en,
  output logic             o_pipe_rst,
  output logic             o_dump_req,
  input  logic             i_dump_done,
  output logic [CYC_W-1:0] o_cycles,
  output logic [2:0]       o_state,
  output logic             o_halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DUMP   = 3'd3,
    S_HALTED = 3'd4,
    S_PRST   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CYC_W-1:0]   cycles_q, cycles_d;
  logic               halted_q, halted_d;
  logic               dump_req_q, dump_req_d;
  logic               pipe_rst_q, pipe_rst_d;
  logic               cmd_acc;

  // Moore decodes: readiness and pipeline enable depend only on the state.
  assign o_cmd_ready = (state_q == S_IDLE) || (state_q == S_HALTED);
  assign o_pipe_en   = (state_q == S_RUN)  || (state_q == S_STEP);
  assign cmd_acc     = i_cmd_valid && o_cmd_ready;

  // Next-state logic: commands only steer IDLE and HALTED; halt wins in RUN.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          case (i_cmd)
            CMD_RUN:  state_d = S_RUN;
            CMD_STEP: state_d = S_STEP;
            CMD_DUMP: state_d = S_DUMP;
            CMD_RST:  state_d = S_PRST;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        if (i_halt) state_d = S_HALTED;
      end
      S_STEP: begin
        state_d = i_halt ? S_HALTED : S_DUMP;
      end
      S_DUMP: begin
        if (i_dump_done) state_d = halted_q ? S_HALTED : S_IDLE;
      end
      S_HALTED: begin
        if (cmd_acc) begin
          if (i_cmd == CMD_DUMP)     state_d = S_DUMP;
          else if (i_cmd == CMD_RST) state_d = S_PRST;
        end
      end
      S_PRST:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up
  // with the cycle in which that state is current.
  always_comb begin
    cycles_d   = cycles_q;
    halted_d   = halted_q;
    dump_req_d = (state_d == S_DUMP);
    pipe_rst_d = (state_d == S_PRST);
    if (o_pipe_en) cycles_d = cycles_q + CYC_W'(1);
    if (state_d == S_HALTED) halted_d = 1'b1;
    if (state_d == S_PRST) begin
      cycles_d = '0;
      halted_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= S_IDLE;
      cycles_q   <= '0;
      halted_q   <= 1'b0;
      dump_req_q <= 1'b0;
      pipe_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycles_q   <= cycles_d;
      halted_q   <= halted_d;
      dump_req_q <= dump_req_d;
      pipe_rst_q <= pipe_rst_d;
    end
  end

  assign o_cycles   = cycles_q;
  assign o_halted   = halted_q;
  assign o_dump_req = dump_req_q;
  assign o_pipe_rst = pipe_rst_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Self-checking bench for debug_run_ctrl. A scenario-level model keeps the
// expected cycle count and halted flag; each operation predicts its outcome
// from those with plain arithmetic.
module tb_debug_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_cmd;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_halt;
  logic        o_pipe_en;
  logic        o_pipe_rst;
  logic        o_dump_req;
  logic        i_dump_done;
  logic [31:0] o_cycles;
  logic [2:0]  o_state;
  logic        o_halted;

  // Narrow-counter instance used to observe wraparound.
  logic [7:0]  w_cmd;
  logic        w_cmd_valid, w_cmd_ready, w_halt, w_pipe_en, w_pipe_rst;
  logic        w_dump_req, w_dump_done, w_halted;
  logic [3:0]  w_cycles;
  logic [2:0]  w_state;

  int          n_checks = 0;
  int          n_errors = 0;
  int          pe_count = 0;
  int          pr_count = 0;
  logic [31:0] exp_cycles;
  logic        exp_halted;

  always #5 clk = ~clk;

  debug_run_ctrl u_dut (
    .clk(clk), .reset(reset), .i_cmd(i_cmd), .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready), .i_halt(i_halt), .o_pipe_en(o_pipe_en),
    .o_pipe_rst(o_pipe_rst), .o_dump_req(o_dump_req),
    .i_dump_done(i_dump_done), .o_cycles(o_cycles), .o_state(o_state),
    .o_halted(o_halted)
  );

  debug_run_ctrl #(.CYC_W(4)) u_dut_w (
    .clk(clk), .reset(reset), .i_cmd(w_cmd), .i_cmd_valid(w_cmd_valid),
    .o_cmd_ready(w_cmd_ready), .i_halt(w_halt), .o_pipe_en(w_pipe_en),
    .o_pipe_rst(w_pipe_rst), .o_dump_req(w_dump_req),
    .i_dump_done(w_dump_done), .o_cycles(w_cycles), .o_state(w_state),
    .o_halted(w_halted)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (o_pipe_en)  pe_count++;
    if (o_pipe_rst) pr_count++;
  endtask

  task automatic send(input logic [7:0] b);
    i_cmd = b;
    i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  function automatic logic [2:0] rest_state();
    return exp_halted ? 3'd4 : 3'd0;
  endfunction

  task automatic test_reset();
    logic [6:0] want;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    exp_cycles = '0;
    exp_halted = 1'b0;
    want = {3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    n_checks++;
    if ({o_state, o_pipe_en, o_cmd_ready, o_dump_req, o_halted} !== want) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b want %b",
               {o_state, o_pipe_en, o_cmd_ready, o_dump_req, o_halted}, want);
    end
    n_checks++;
    if (o_cycles !== 32'd0 || o_pipe_rst !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_cycles: got %0d rst=%b want 0 rst=0", o_cycles, o_pipe_rst);
    end
  endtask

  // Continuous run for n cycles, halt retiring in the last one. Optionally
  // inject commands that must be dropped, including one on the halt cycle.
  task automatic op_run(input int n, input bit inject);
    logic [7:0] picks [4];
    picks = '{8'h53, 8'hFF, 8'h44, 8'h52};
    send(8'h43);
    if (exp_halted) begin
      n_checks++;
      if (o_state !== 3'd4 || o_cycles !== exp_cycles || o_pipe_en !== 1'b0) begin
        n_errors++;
        $display("FAIL run_after_halt: got st=%0d cyc=%0d en=%b want st=4 cyc=%0d en=0",
                 o_state, o_cycles, o_pipe_en, exp_cycles);
      end
      return;
    end
    for (int i = 1; i < n; i++) begin
      n_checks++;
      if ({o_state, o_pipe_en, o_cmd_ready} !== {3'd1, 1'b1, 1'b0}) begin
        n_errors++;
        $display("FAIL run_busy: got st=%0d en=%b rdy=%b want st=1 en=1 rdy=0",
                 o_state, o_pipe_en, o_cmd_ready);
      end
      if (inject && $urandom_range(0, 1) == 1) begin
        i_cmd = picks[$urandom_range(0, 3)];
        i_cmd_valid = 1'b1;
      end
      tick();
      i_cmd_valid = 1'b0;
    end
    i_halt = 1'b1;
    if (inject) begin
      i_cmd = 8'h44;
      i_cmd_valid = 1'b1;
    end
    tick();
    i_halt = 1'b0;
    i_cmd_valid = 1'b0;
    exp_cycles = exp_cycles + 32'(n);
    exp_halted = 1'b1;
    n_checks++;
    if ({o_state, o_pipe_en, o_halted, o_cmd_ready} !== {3'd4, 1'b0, 1'b1, 1'b1}) begin
      n_errors++;
      $display("FAIL run_halt_state: got st=%0d en=%b hlt=%b rdy=%b want st=4 en=0 hlt=1 rdy=1",
               o_state, o_pipe_en, o_halted, o_cmd_ready);
    end
    n_checks++;
    if (o_cycles !== exp_cycles) begin
      n_errors++;
      $display("FAIL run_cycles: got %0d want %0d", o_cycles, exp_cycles);
    end
  endtask

  // Wait out a pending dump: done is raised d cycles after the request rose.
  task automatic finish_dump(input int d);
    for (int i = 1; i < d; i++) begin
      tick();
      n_checks++;
      if ({o_state, o_dump_req, o_pipe_en} !== {3'd3, 1'b1, 1'b0}) begin
        n_errors++;
        $display("FAIL dump_hold: got st=%0d req=%b en=%b want st=3 req=1 en=0",
                 o_state, o_dump_req, o_pipe_en);
      end
    end
    i_dump_done = 1'b1;
    tick();
    i_dump_done = 1'b0;
    n_checks++;
    if (o_state !== rest_state() || o_dump_req !== 1'b0) begin
      n_errors++;
      $display("FAIL dump_return: got st=%0d req=%b want st=%0d req=0",
               o_state, o_dump_req, rest_state());
    end
  endtask

  task automatic op_dump(input int d);
    send(8'h44);
    n_checks++;
    if (o_state !== 3'd3 || o_dump_req !== 1'b1) begin
      n_errors++;
      $display("FAIL dump_start: got st=%0d req=%b want st=3 req=1", o_state, o_dump_req);
    end
    finish_dump(d);
  endtask

  task automatic op_step(input int d, input bit halt_now);
    int pe0;
    pe0 = pe_count;
    send(8'h53);
    if (exp_halted) begin
      n_checks++;
      if (o_state !== 3'd4 || o_cycles !== exp_cycles || pe_count != pe0) begin
        n_errors++;
        $display("FAIL step_after_halt: got st=%0d cyc=%0d want st=4 cyc=%0d",
                 o_state, o_cycles, exp_cycles);
      end
      return;
    end
    i_halt = halt_now;
    tick();
    i_halt = 1'b0;
    exp_cycles = exp_cycles + 32'd1;
    if (halt_now) exp_halted = 1'b1;
    n_checks++;
    if (o_cycles !== exp_cycles || o_halted !== exp_halted) begin
      n_errors++;
      $display("FAIL step_cycles: got cyc=%0d hlt=%b want cyc=%0d hlt=%b",
               o_cycles, o_halted, exp_cycles, exp_halted);
    end
    if (halt_now) begin
      n_checks++;
      if (o_state !== 3'd4 || o_dump_req !== 1'b0) begin
        n_errors++;
        $display("FAIL step_halt: got st=%0d req=%b want st=4 req=0", o_state, o_dump_req);
      end
    end else begin
      n_checks++;
      if (o_state !== 3'd3 || o_dump_req !== 1'b1) begin
        n_errors++;
        $display("FAIL step_autodump: got st=%0d req=%b want st=3 req=1", o_state, o_dump_req);
      end
      finish_dump(d);
    end
    n_checks++;
    if (pe_count - pe0 != 1) begin
      n_errors++;
      $display("FAIL step_pulses: got %0d want 1", pe_count - pe0);
    end
  endtask

  task automatic op_prst();
    int pr0;
    pr0 = pr_count;
    send(8'h52);
    exp_cycles = '0;
    exp_halted = 1'b0;
    n_checks++;
    if ({o_state, o_pipe_rst, o_halted, o_pipe_en} !== {3'd5, 1'b1, 1'b0, 1'b0} ||
        o_cycles !== 32'd0) begin
      n_errors++;
      $display("FAIL prst_pulse: got st=%0d rst=%b hlt=%b en=%b cyc=%0d want st=5 rst=1 hlt=0 en=0 cyc=0",
               o_state, o_pipe_rst, o_halted, o_pipe_en, o_cycles);
    end
    tick(); tick();
    n_checks++;
    if (o_state !== 3'd0 || pr_count - pr0 != 1) begin
      n_errors++;
      $display("FAIL prst_done: got st=%0d pulses=%0d want st=0 pulses=1",
               o_state, pr_count - pr0);
    end
  endtask

  task automatic op_garbage();
    logic [7:0] b;
    b = 8'($urandom);
    while (b inside {8'h43, 8'h53, 8'h44, 8'h52}) b = 8'($urandom);
    send(b);
    n_checks++;
    if (o_state !== rest_state() || o_cycles !== exp_cycles || o_cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL garbage_byte %h: got st=%0d cyc=%0d rdy=%b want st=%0d cyc=%0d rdy=1",
               b, o_state, o_cycles, o_cmd_ready, rest_state(), exp_cycles);
    end
  endtask

  task automatic op_stray_done();
    i_dump_done = 1'b1;
    tick();
    i_dump_done = 1'b0;
    tick();
    n_checks++;
    if (o_state !== rest_state() || o_dump_req !== 1'b0) begin
      n_errors++;
      $display("FAIL stray_done: got st=%0d req=%b want st=%0d req=0",
               o_state, o_dump_req, rest_state());
    end
  endtask

  task automatic test_run_halt();
    op_run(25, 1'b0);
    n_checks++;
    if (o_cycles !== 32'd25) begin
      n_errors++;
      $display("FAIL run25_cycles: got %0d want 25", o_cycles);
    end
    op_step(4, 1'b0);
    op_run(5, 1'b0);
  endtask

  task automatic test_dump_prst();
    op_dump(4);
    n_checks++;
    if (o_halted !== 1'b1 || o_cycles !== 32'd25) begin
      n_errors++;
      $display("FAIL halted_dump: got hlt=%b cyc=%0d want hlt=1 cyc=25", o_halted, o_cycles);
    end
    op_prst();
  endtask

  task automatic test_step();
    for (int k = 0; k < 3; k++) op_step(4, 1'b0);
    n_checks++;
    if (o_cycles !== 32'd3 || o_state !== 3'd0) begin
      n_errors++;
      $display("FAIL step3: got cyc=%0d st=%0d want cyc=3 st=0", o_cycles, o_state);
    end
  endtask

  task automatic test_drop_in_run();
    op_run(12, 1'b1);
    op_prst();
    send(8'hFF);
    n_checks++;
    if (o_state !== 3'd0 || o_cycles !== 32'd0) begin
      n_errors++;
      $display("FAIL idle_ff: got st=%0d cyc=%0d want st=0 cyc=0", o_state, o_cycles);
    end
    op_stray_done();
  endtask

  task automatic test_reset_in_dump();
    send(8'h53);
    tick();
    n_checks++;
    if (o_state !== 3'd3 || o_dump_req !== 1'b1) begin
      n_errors++;
      $display("FAIL rid_setup: got st=%0d req=%b want st=3 req=1", o_state, o_dump_req);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cycles = '0;
    exp_halted = 1'b0;
    n_checks++;
    if ({o_state, o_dump_req, o_halted} !== {3'd0, 1'b0, 1'b0} || o_cycles !== 32'd0) begin
      n_errors++;
      $display("FAIL rid_reset: got st=%0d req=%b cyc=%0d want st=0 req=0 cyc=0",
               o_state, o_dump_req, o_cycles);
    end
    op_stray_done();
  endtask

  task automatic test_wrap();
    int n;
    n = $urandom_range(17, 40);
    w_cmd = 8'h43;
    w_cmd_valid = 1'b1;
    tick();
    w_cmd_valid = 1'b0;
    for (int i = 1; i < n; i++) tick();
    w_halt = 1'b1;
    tick();
    w_halt = 1'b0;
    n_checks++;
    if (w_cycles !== 4'(n % 16) || w_state !== 3'd4) begin
      n_errors++;
      $display("FAIL wrap: n=%0d got cyc=%0d st=%0d want cyc=%0d st=4",
               n, w_cycles, w_state, n % 16);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 5))
        0: op_run($urandom_range(1, 40), 1'b1);
        1: op_step($urandom_range(1, 6), 1'($urandom_range(0, 1)));
        2: op_dump($urandom_range(1, 6));
        3: op_prst();
        4: op_garbage();
        default: op_stray_done();
      endcase
    end
  endtask

  initial begin
    reset = 1'b0;
    i_cmd = '0; i_cmd_valid = 1'b0; i_halt = 1'b0; i_dump_done = 1'b0;
    w_cmd = '0; w_cmd_valid = 1'b0; w_halt = 1'b0; w_dump_done = 1'b0;
    exp_cycles = '0;
    exp_halted = 1'b0;
    test_reset();
    test_run_halt();
    test_dump_prst();
    test_step();
    test_drop_in_run();
    test_reset_in_dump();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
